ct_butterfly_addsub: RTL and testbench

Downstream stage of the modular reducer in the NTT datapath. It completes a Cooley-Tukey butterfly: it takes the reduced twiddle product t = (zeta·b) mod q from the reducer and pairs it with operand a. Operand a is captured when the multiply is issued and held in an internal alignment FIFO, so the block absorbs the reducer's latency. It outputs (a + t) mod q and (a − t) mod q through a 2-stage pipeline and flags FIFO misuse.

---
 rtl/ct_butterfly_addsub.sv | 98 +++++++++
 tb/tb_ct_butterfly_addsub.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_butterfly_addsub.sv
// Cooley-Tukey butterfly tail: pairs the reduced twiddle product t with operand a
// (held in an alignment FIFO across the reducer latency) and emits (a+t) mod Q, (a-t) mod Q.
module ct_butterfly_addsub #(
    parameter int Q          = 3329,
    parameter int FIFO_DEPTH = 4,
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid_i,
    input  logic [11:0]   a_i,
    input  logic          t_valid_i,
    input  logic [11:0]   t_i,
    input  logic          flush_i,
    output logic          valid_o,
    output logic [11:0]   sum_o,
    output logic [11:0]   diff_o,
    output logic [LW-1:0] fifo_level_o,
    output logic          overflow_o,
    output logic          underflow_o
);
    localparam int          PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          STAGES = 2;
    localparam logic [12:0] QW     = 13'(Q);

    logic [11:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [LW-1:0]     level;
    logic [STAGES:1]   vld_pipe;
    logic [12:0]       s1_sum, s1_diff;
    logic              full, empty, pop, push, ovf_evt, udf_evt;
    logic [11:0]       head;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];
    // Pop only sees entries stored on an earlier edge, so a same-cycle push never rescues an empty pop.
    assign pop     = t_valid_i & ~empty;
    assign push    = a_valid_i & (~full | pop);
    assign ovf_evt = a_valid_i & full & ~pop;
    assign udf_evt = t_valid_i & empty;

    // Control state: pointers, level, valid pipeline, sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            vld_pipe    <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            vld_pipe    <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            vld_pipe    <= {vld_pipe[STAGES-1:1], pop};
            overflow_o  <= overflow_o | ovf_evt;
            underflow_o <= underflow_o | udf_evt;
        end
    end

    // Datapath: FIFO storage and the two arithmetic stages; flush leaves data alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            s1_sum  <= '0;
            s1_diff <= '0;
            sum_o   <= '0;
            diff_o  <= '0;
        end else begin
            if (push && !flush_i) mem[wr_ptr] <= a_i;
            if (pop) begin
                s1_sum  <= {1'b0, head} + {1'b0, t_i};
                // Bias by Q so the difference stays non-negative in 13 bits.
                s1_diff <= {1'b0, head} + QW - {1'b0, t_i};
            end
            if (vld_pipe[1]) begin
                sum_o  <= (s1_sum  >= QW) ? 12'(s1_sum  - QW) : s1_sum[11:0];
                diff_o <= (s1_diff >= QW) ? 12'(s1_diff - QW) : s1_diff[11:0];
            end
        end
    end

    assign valid_o      = vld_pipe[STAGES];
    assign fifo_level_o = level;

endmodule

// File: tb/tb_ct_butterfly_addsub.sv
// Directed + random bench for ct_butterfly_addsub against a queue-based modular-arithmetic model.
module tb_ct_butterfly_addsub;
    localparam int Q = 3329;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid_i, t_valid_i, flush_i;
    logic [11:0] a_i, t_i;
    logic        valid_o, overflow_o, underflow_o;
    logic [11:0] sum_o, diff_o;
    logic [2:0]  fifo_level_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    bit m_s1_v, m_v, m_ovf, m_udf;
    int m_s1_sum, m_s1_diff, m_sum, m_diff;

    ct_butterfly_addsub #(.Q(Q), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .a_valid_i(a_valid_i), .a_i(a_i),
        .t_valid_i(t_valid_i), .t_i(t_i),
        .flush_i(flush_i),
        .valid_o(valid_o), .sum_o(sum_o), .diff_o(diff_o),
        .fifo_level_o(fifo_level_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_s1_v = 0; m_v = 0; m_ovf = 0; m_udf = 0;
        m_s1_sum = 0; m_s1_diff = 0; m_sum = 0; m_diff = 0;
    endtask

    task automatic model_step();
        bit pv, popped;
        int ps, pd, sz0, ah;
        if (!rst) begin
            model_reset();
            return;
        end
        pv = m_s1_v; ps = m_s1_sum; pd = m_s1_diff;
        if (flush_i) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_s1_v = 0; m_v = 0;
            return;
        end
        sz0 = q.size();
        popped = 0;
        if (t_valid_i) begin
            if (sz0 > 0) begin
                ah = q.pop_front();
                popped = 1;
                m_s1_sum  = (ah + int'(t_i)) % Q;
                m_s1_diff = (ah + Q - int'(t_i)) % Q;
            end else m_udf = 1;
        end
        if (a_valid_i) begin
            if (sz0 < D || popped) q.push_back(int'(a_i));
            else m_ovf = 1;
        end
        m_v = pv;
        if (pv) begin m_sum = ps; m_diff = pd; end
        m_s1_v = popped;
    endtask

    task automatic check_all();
        chk("valid_o", valid_o, m_v);
        chk("fifo_level_o", fifo_level_o, q.size());
        chk("overflow_o", overflow_o, m_ovf);
        chk("underflow_o", underflow_o, m_udf);
        if (m_v) begin
            chk("sum_o", sum_o, m_sum);
            chk("diff_o", diff_o, m_diff);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        a_valid_i = 0; t_valid_i = 0; flush_i = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_sum"}, sum_o, 0);
        chk({tag, "_diff"}, diff_o, 0);
        chk({tag, "_level"}, fifo_level_o, 0);
        chk({tag, "_ovf"}, overflow_o, 0);
        chk({tag, "_udf"}, underflow_o, 0);
    endtask

    task automatic do_flush();
        idle(); flush_i = 1; tick(); flush_i = 0;
    endtask

    task automatic corner(input int a, input int t, input int es, input int ed);
        idle(); a_valid_i = 1; a_i = 12'(a); tick();
        idle(); t_valid_i = 1; t_i = 12'(t); tick();
        idle(); chk("corner_early_valid", valid_o, 0);
        tick();
        chk("corner_valid", valid_o, 1);
        chk("corner_sum", sum_o, es);
        chk("corner_diff", diff_o, ed);
        tick();
    endtask

    initial begin
        int peak, beats;
        int got_q[$];
        rst = 1; a_i = 0; t_i = 0;
        idle();
        model_reset();
        #2 rst = 0;
        #1 chk_zero("reset");
        tick(); tick();
        #2 rst = 1;

        // Arithmetic corners
        corner(3000, 500, 171, 2500);
        corner(100, 3328, 99, 101);
        corner(3328, 3328, 3327, 0);
        corner(0, 0, 0, 0);

        // Streaming alignment: t stream trails a stream by 3 cycles
        peak = 0; beats = 0;
        for (int c = 0; c < 14; c++) begin
            idle();
            if (c < 8) begin a_valid_i = 1; a_i = 12'(c + 1); end
            if (c >= 3 && c < 11) begin t_valid_i = 1; t_i = 12'(10 * (c - 2)); end
            tick();
            if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);
            if (valid_o) begin
                beats++;
                chk("stream_sum", sum_o, 11 * beats);
                chk("stream_diff", diff_o, Q - 9 * beats);
            end
        end
        chk("stream_peak", peak, 3);
        chk("stream_beats", beats, 8);
        chk("stream_final_level", fifo_level_o, 0);

        // Overflow: five pushes into a four-deep FIFO
        for (int k = 1; k <= 5; k++) begin
            idle(); a_valid_i = 1; a_i = 12'(k); tick();
        end
        idle();
        chk("ovf_level", fifo_level_o, 4);
        chk("ovf_flag", overflow_o, 1);
        for (int k = 0; k < 7; k++) begin
            idle();
            if (k < 4) begin t_valid_i = 1; t_i = 0; end
            tick();
            if (valid_o) got_q.push_back(int'(sum_o));
        end
        chk("ovf_pop_count", got_q.size(), 4);
        for (int k = 0; k < got_q.size() && k < 4; k++) chk("ovf_pop_value", got_q[k], k + 1);
        do_flush();

        // Underflow with simultaneous push
        idle(); t_valid_i = 1; t_i = 5; a_valid_i = 1; a_i = 7; tick();
        idle();
        chk("udf_flag", underflow_o, 1);
        chk("udf_level", fifo_level_o, 1);
        tick();
        chk("udf_no_valid", valid_o, 0);
        t_valid_i = 1; t_i = 5; tick();
        idle(); tick();
        chk("udf_late_sum", sum_o, 12);
        do_flush();

        // Full FIFO with simultaneous push+pop
        for (int k = 0; k < 4; k++) begin
            idle(); a_valid_i = 1; a_i = 12'(20 + k); tick();
        end
        idle(); a_valid_i = 1; a_i = 24; t_valid_i = 1; t_i = 1; tick();
        idle();
        chk("full_pp_level", fifo_level_o, 4);
        chk("full_pp_ovf", overflow_o, 0);
        for (int k = 0; k < 6; k++) begin
            idle(); if (k < 4) begin t_valid_i = 1; t_i = 1; end
            tick();
        end
        do_flush();

        // Flush with level=3, s1 valid and overflow set; push in the flush cycle is discarded
        for (int k = 1; k <= 5; k++) begin
            idle(); a_valid_i = 1; a_i = 12'(k); tick();
        end
        idle(); t_valid_i = 1; t_i = 100; tick();
        chk("pre_flush_level", fifo_level_o, 3);
        idle(); flush_i = 1; a_valid_i = 1; a_i = 9; tick();
        idle();
        chk("flush_level", fifo_level_o, 0);
        chk("flush_ovf", overflow_o, 0);
        chk("flush_valid", valid_o, 0);
        tick();
        chk("flush_valid_next", valid_o, 0);
        chk("flush_level_next", fifo_level_o, 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            a_valid_i = ($urandom_range(0, 99) < 55);
            a_i = 12'($urandom_range(0, Q - 1));
            t_valid_i = ($urandom_range(0, 99) < 50);
            t_i = 12'($urandom_range(0, Q - 1));
            flush_i = ($urandom_range(0, 99) < 3);
            tick();
        end

        // Reset mid-stream
        idle(); a_valid_i = 1; a_i = 11; tick();
        a_i = 12; t_valid_i = 1; t_i = 3; tick();
        #3 rst = 0;
        #1 chk_zero("midrst");
        model_reset();
        tick(); tick();
        rst = 1;
        idle(); tick();
        chk("post_rst_no_valid", valid_o, 0);
        corner(1234, 2000, 3234, 2563);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
